pc_trace_buffer: RTL

PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

---
 rtl/pc_trace_buffer_pkg.sv | 22 ++
 rtl/pc_trace_ram.sv | 30 +++
 rtl/pc_trace_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pc_trace_buffer_pkg.sv
// rtl/pc_trace_buffer_pkg.sv - shared state/mode encodings for the PC trace buffer
package pc_trace_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POST    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_WRAP = 2'd0,
      MODE_STOP = 2'd1,
      MODE_TRIG = 2'd2
   } mode_t;

   // The reserved encoding 3 behaves as plain wrap mode.
   function automatic mode_t decode_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_WRAP : mode_t'(m);
   endfunction

endpackage

// File: rtl/pc_trace_ram.sv
// rtl/pc_trace_ram.sv - trace storage, one write port and one registered read port
module pc_trace_ram #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [ADDR_W-1:0] wdata,
   input  logic              re,
   input  logic              rzero,
   input  logic [AW-1:0]     raddr,
   output logic [ADDR_W-1:0] rdata
);

   logic [ADDR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Reading the array with non-blocking semantics yields the pre-write value on a collision.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= rzero ? '0 : mem[raddr];
   end

endmodule

// File: rtl/pc_trace_buffer.sv
// rtl/pc_trace_buffer.sv - PC trace capture with wrap, stop-on-full and trigger modes plus hang detect
module pc_trace_buffer
   import pc_trace_buffer_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int STALL_CYC = 8,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              pc_valid,
   input  logic              arm,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] trig_addr,
   input  logic [AW-1:0]     rd_idx,
   input  logic              rd_en,
   output logic [ADDR_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [CW-1:0]     count,
   output logic              busy,
   output logic              done,
   output logic              wrapped,
   output logic              stall
);

   localparam int SW = $clog2(STALL_CYC) + 1;

   state_t            state;
   mode_t             mode_q;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     post_cnt;
   logic [CW-1:0]     count_q;
   logic [ADDR_W-1:0] last_pc;
   logic [ADDR_W-1:0] prev_pc;
   logic              prev_seen;
   logic [SW-1:0]     stall_cnt;

   logic              capturing;
   logic              full;
   logic              wr_en;
   logic [AW-1:0]     oldest;
   logic [AW-1:0]     raddr;
   logic              rzero;

   assign capturing = (state == ST_CAPTURE) || (state == ST_POST);
   assign full      = (count_q == CW'(DEPTH));
   assign wr_en     = capturing && pc_valid && !arm && ((count_q == '0) || (pc_in != last_pc));
   // Once the buffer has filled, the next write slot is also the oldest entry.
   assign oldest    = full ? wr_ptr : '0;
   assign raddr     = oldest + rd_idx;
   assign rzero     = ({1'b0, rd_idx} >= count_q);

   assign count = count_q;
   assign busy  = capturing;
   assign done  = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_WRAP;
         wr_ptr    <= '0;
         post_cnt  <= '0;
         count_q   <= '0;
         last_pc   <= '0;
         prev_pc   <= '0;
         prev_seen <= 1'b0;
         stall_cnt <= '0;
         wrapped   <= 1'b0;
         stall     <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (arm) begin
            state     <= ST_CAPTURE;
            mode_q    <= decode_mode(mode);
            wr_ptr    <= '0;
            post_cnt  <= '0;
            count_q   <= '0;
            prev_seen <= 1'b0;
            stall_cnt <= '0;
            wrapped   <= 1'b0;
            stall     <= 1'b0;
         end else begin
            if (wr_en) begin
               wr_ptr  <= wr_ptr + 1'b1;
               last_pc <= pc_in;
               if (!full) count_q <= count_q + 1'b1;
               else       wrapped <= 1'b1;
               if (mode_q == MODE_STOP && count_q == CW'(DEPTH - 1)) begin
                  state <= ST_DONE;
               end else if (mode_q == MODE_TRIG) begin
                  if (state == ST_CAPTURE && pc_in == trig_addr) begin
                     post_cnt <= AW'(1);
                     state    <= (POST_TRIG == 1) ? ST_DONE : ST_POST;
                  end else if (state == ST_POST) begin
                     post_cnt <= post_cnt + 1'b1;
                     if (post_cnt + 1'b1 == AW'(POST_TRIG)) state <= ST_DONE;
                  end
               end
            end
            // Hang detection watches raw samples, independent of the change-only filter.
            if (state != ST_IDLE && pc_valid) begin
               prev_pc   <= pc_in;
               prev_seen <= 1'b1;
               if (prev_seen && pc_in == prev_pc) begin
                  if (stall_cnt < SW'(STALL_CYC - 1)) stall_cnt <= stall_cnt + 1'b1;
                  if (stall_cnt >= SW'(STALL_CYC - 2)) stall <= 1'b1;
               end else begin
                  stall_cnt <= '0;
               end
            end
         end
      end
   end

   pc_trace_ram #(
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_en),
      .waddr(wr_ptr),
      .wdata(pc_in),
      .re   (rd_en),
      .rzero(rzero),
      .raddr(raddr),
      .rdata(rd_data)
   );

endmodule
